// File: rtl/apb_mig_ctrl_pkg.sv
// Shared types and constants for the APB-to-MIG user interface bridge.
package apb_mig_ctrl_pkg;

    localparam int LANES          = 4;
    localparam int LINE_BYTES     = 16;
    localparam int APP_ADDR_W_DEF = 27;

    typedef logic [APP_ADDR_W_DEF-1:0] app_addr_t;
    typedef logic [8*LINE_BYTES-1:0]   app_data_t;
    typedef logic [LINE_BYTES-1:0]     app_mask_t;

    typedef enum logic [2:0] {
        APP_CMD_WRITE = 3'b000,
        APP_CMD_READ  = 3'b001
    } app_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_CMD,
        ST_RD_WAIT,
        ST_RESP
    } ctrl_state_e;

endpackage

// File: rtl/apb_mig_ctrl_if.sv
// APB completer port plus MIG app_* port bundled together; clock/reset stay outside.
interface apb_mig_ctrl_if #(
    parameter int APP_ADDR_W = 27
);
    import apb_mig_ctrl_pkg::*;

    logic [31:0]           paddr_i;
    logic [31:0]           pwdata_i;
    logic                  pwrite_i;
    logic                  psel_i;
    logic                  penable_i;
    logic [3:0]            pstrb_i;
    logic [31:0]           prdata_o;
    logic                  pready_o;
    logic                  pslverr_o;
    logic                  init_calib_complete_i;
    logic [APP_ADDR_W-1:0] app_addr_o;
    logic [2:0]            app_cmd_o;
    logic                  app_en_o;
    logic                  app_rdy_i;
    app_data_t             app_wdf_data_o;
    app_mask_t             app_wdf_mask_o;
    logic                  app_wdf_wren_o;
    logic                  app_wdf_end_o;
    logic                  app_wdf_rdy_i;
    app_data_t             app_rd_data_i;
    logic                  app_rd_data_valid_i;

    // The bridge itself
    modport slave (
        input  paddr_i, pwdata_i, pwrite_i, psel_i, penable_i, pstrb_i,
        input  init_calib_complete_i, app_rdy_i, app_wdf_rdy_i,
        input  app_rd_data_i, app_rd_data_valid_i,
        output prdata_o, pready_o, pslverr_o,
        output app_addr_o, app_cmd_o, app_en_o,
        output app_wdf_data_o, app_wdf_mask_o, app_wdf_wren_o, app_wdf_end_o
    );

    // The surroundings: APB requester and MIG core
    modport master (
        output paddr_i, pwdata_i, pwrite_i, psel_i, penable_i, pstrb_i,
        output init_calib_complete_i, app_rdy_i, app_wdf_rdy_i,
        output app_rd_data_i, app_rd_data_valid_i,
        input  prdata_o, pready_o, pslverr_o,
        input  app_addr_o, app_cmd_o, app_en_o,
        input  app_wdf_data_o, app_wdf_mask_o, app_wdf_wren_o, app_wdf_end_o
    );

endinterface

// File: rtl/apb_mig_ctrl_lane_map.sv
// Maps a 32-bit APB word onto one 32-bit lane of a 128-bit MIG line and back.
module apb_mig_lane_map
    import apb_mig_ctrl_pkg::*;
(
    input  logic [$clog2(LANES)-1:0] lane,
    input  logic [31:0]              pwdata,
    input  logic [3:0]               pstrb,
    input  app_data_t                rd_data,
    output app_data_t                wdf_data,
    output app_mask_t                wdf_mask,
    output logic [31:0]              prdata
);

    // Word goes to every lane; the mask alone decides which bytes land.
    assign wdf_data = {LANES{pwdata}};
    // Mask is active-high "do not write": clear only the strobed bytes of the chosen lane.
    assign wdf_mask = ~(app_mask_t'(pstrb) << {lane, 2'b00});
    assign prdata   = rd_data[{lane, 5'b00000} +: 32];

endmodule

// File: rtl/apb_mig_ctrl.sv
// APB completer that turns each transfer into at most one MIG app_* command.
module apb_mig_ctrl
    import apb_mig_ctrl_pkg::*;
#(
    parameter int APP_ADDR_W     = 27,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic          pclk_i,
    input  logic          preset_i,
    apb_mig_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    ctrl_state_e           state, state_nxt;
    logic                  cmd_done, cmd_done_nxt, wdf_done, wdf_done_nxt;
    logic                  err, err_nxt;
    logic [CNT_W-1:0]      tmo_cnt, tmo_cnt_nxt;
    logic [1:0]            lane_q, lane_sel;
    logic                  start, req_err, cmd_hs, wdf_hs;

    logic                  app_en_q, app_en_d, wren_q, wren_d;
    logic                  pready_q, pready_d, pslverr_q, pslverr_d;
    logic [31:0]           prdata_q, rd_word;
    logic [APP_ADDR_W-1:0] app_addr_q;
    app_cmd_e              app_cmd_q;
    app_data_t             wdf_data_q, wdf_data;
    app_mask_t             wdf_mask_q, wdf_mask;

    assign start   = bus.psel_i && bus.penable_i;
    assign req_err = !bus.init_calib_complete_i || (bus.paddr_i[1:0] != 2'b00) ||
                     ((bus.paddr_i >> (APP_ADDR_W + 1)) != 32'd0);
    assign cmd_hs  = app_en_q && bus.app_rdy_i;
    assign wdf_hs  = wren_q && bus.app_wdf_rdy_i;
    // Live address while capturing a write line, captured lane while extracting read data.
    assign lane_sel = (state == ST_IDLE) ? bus.paddr_i[3:2] : lane_q;

    apb_mig_lane_map u_lane_map (
        .lane     (lane_sel),
        .pwdata   (bus.pwdata_i),
        .pstrb    (bus.pstrb_i),
        .rd_data  (bus.app_rd_data_i),
        .wdf_data (wdf_data),
        .wdf_mask (wdf_mask),
        .prdata   (rd_word)
    );

    // State, handshake flags, captured request and registered outputs.
    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) begin
            state      <= ST_IDLE;
            cmd_done   <= 1'b0;
            wdf_done   <= 1'b0;
            err        <= 1'b0;
            tmo_cnt    <= '0;
            lane_q     <= '0;
            app_en_q   <= 1'b0;
            wren_q     <= 1'b0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            prdata_q   <= '0;
            app_addr_q <= '0;
            app_cmd_q  <= APP_CMD_WRITE;
            wdf_data_q <= '0;
            wdf_mask_q <= '0;
        end else begin
            state     <= state_nxt;
            cmd_done  <= cmd_done_nxt;
            wdf_done  <= wdf_done_nxt;
            err       <= err_nxt;
            tmo_cnt   <= tmo_cnt_nxt;
            app_en_q  <= app_en_d;
            wren_q    <= wren_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            if (state == ST_IDLE && start) begin
                lane_q   <= bus.paddr_i[3:2];
                prdata_q <= '0;
                // Only a transfer that really goes to the MIG updates the app_* fields.
                if (state_nxt == ST_WR || state_nxt == ST_RD_CMD) begin
                    app_addr_q <= {bus.paddr_i[APP_ADDR_W:4], 3'b000};
                    app_cmd_q  <= bus.pwrite_i ? APP_CMD_WRITE : APP_CMD_READ;
                    wdf_data_q <= wdf_data;
                    wdf_mask_q <= wdf_mask;
                end
            end
            if (state == ST_RD_WAIT && bus.app_rd_data_valid_i)
                prdata_q <= rd_word;
        end
    end

    // Next state, done flags, error and timeout counter.
    always_comb begin
        state_nxt    = state;
        cmd_done_nxt = cmd_done;
        wdf_done_nxt = wdf_done;
        err_nxt      = err;
        tmo_cnt_nxt  = tmo_cnt;
        unique case (state)
            ST_IDLE: begin
                cmd_done_nxt = 1'b0;
                wdf_done_nxt = 1'b0;
                err_nxt      = 1'b0;
                tmo_cnt_nxt  = '0;
                if (start) begin
                    if (req_err) begin
                        state_nxt = ST_RESP;
                        err_nxt   = 1'b1;
                    end else if (bus.pwrite_i && bus.pstrb_i == 4'b0000) begin
                        state_nxt = ST_RESP;
                    end else if (bus.pwrite_i) begin
                        state_nxt = ST_WR;
                    end else begin
                        state_nxt = ST_RD_CMD;
                    end
                end
            end
            ST_WR: begin
                cmd_done_nxt = cmd_done || cmd_hs;
                wdf_done_nxt = wdf_done || wdf_hs;
                if (cmd_done_nxt && wdf_done_nxt) begin
                    state_nxt = ST_RESP;
                end else if (!cmd_done_nxt && !wdf_done_nxt) begin
                    // Timeout only guards the wait for the very first acceptance.
                    tmo_cnt_nxt = tmo_cnt + CNT_W'(1);
                    if (tmo_cnt_nxt == CNT_W'(TIMEOUT_CYCLES)) begin
                        state_nxt = ST_RESP;
                        err_nxt   = 1'b1;
                    end
                end
            end
            ST_RD_CMD: begin
                if (cmd_hs) begin
                    state_nxt = ST_RD_WAIT;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + CNT_W'(1);
                    if (tmo_cnt_nxt == CNT_W'(TIMEOUT_CYCLES)) begin
                        state_nxt = ST_RESP;
                        err_nxt   = 1'b1;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (bus.app_rd_data_valid_i) state_nxt = ST_RESP;
            end
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, decoded from where the FSM is heading.
    always_comb begin
        app_en_d  = ((state_nxt == ST_WR) && !cmd_done_nxt) || (state_nxt == ST_RD_CMD);
        wren_d    = (state_nxt == ST_WR) && !wdf_done_nxt;
        pready_d  = (state_nxt == ST_RESP);
        pslverr_d = (state_nxt == ST_RESP) && err_nxt;
    end

    assign bus.prdata_o       = prdata_q;
    assign bus.pready_o       = pready_q;
    assign bus.pslverr_o      = pslverr_q;
    assign bus.app_addr_o     = app_addr_q;
    assign bus.app_cmd_o      = app_cmd_q;
    assign bus.app_en_o       = app_en_q;
    assign bus.app_wdf_data_o = wdf_data_q;
    assign bus.app_wdf_mask_o = wdf_mask_q;
    assign bus.app_wdf_wren_o = wren_q;
    assign bus.app_wdf_end_o  = wren_q;

endmodule

// File: tb/tb_apb_mig_ctrl.sv
// Scoreboard bench for apb_mig_ctrl: directed APB transfers against a small MIG model.
module tb_apb_mig_ctrl;
    import apb_mig_ctrl_pkg::*;

    localparam int AW  = 27;
    localparam int TMO = 8;

    typedef struct { logic [31:0] rdata; logic err; int lat; } resp_t;
    typedef struct { logic [AW-1:0] addr; logic [2:0] cmd; } cmd_t;
    typedef struct { app_data_t data; app_mask_t mask; } wdf_t;

    logic pclk = 1'b0;
    logic preset = 1'b1;
    always #5 pclk = ~pclk;

    apb_mig_ctrl_if #(.APP_ADDR_W(AW)) bus ();

    apb_mig_ctrl #(.APP_ADDR_W(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .pclk_i   (pclk),
        .preset_i (preset),
        .bus      (bus)
    );

    resp_t resp_q[$];
    cmd_t  cmd_q[$];
    wdf_t  wdf_q[$];

    int checks = 0, errors = 0;
    int cmd_dly = 0, wdf_dly = 0, rd_dly = 5;
    app_data_t rd_line = '0;
    int acc_cyc = 0, en_rises = 0, exp_en_rises = 0, en_run = 0, last_en_len = 0;
    int rd_hs_cnt = 0;
    logic en_prev = 1'b0;

    assign bus.app_rd_data_i = rd_line;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic outs_zero();
        return bus.prdata_o == 0 && !bus.pready_o && !bus.pslverr_o && bus.app_addr_o == 0 &&
               bus.app_cmd_o == 0 && !bus.app_en_o && !bus.app_wdf_wren_o && !bus.app_wdf_end_o &&
               bus.app_wdf_mask_o == 0 && bus.app_wdf_data_o == 0;
    endfunction

    task automatic expect_cmd(input logic [AW-1:0] a, input logic [2:0] c);
        cmd_q.push_back('{a, c});
        exp_en_rises++;
    endtask

    task automatic expect_wdf(input app_data_t d, input app_mask_t m);
        wdf_q.push_back('{d, m});
    endtask

    // Monitor: APB responses and MIG handshakes, sampled on the falling edge.
    initial forever begin
        @(negedge pclk);
        if (bus.psel_i && bus.penable_i) acc_cyc++; else acc_cyc = 0;
        if (bus.pready_o) begin
            if (resp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_pready: got pready=1, expected none (prdata %0h)", bus.prdata_o);
            end else begin
                resp_t r;
                r = resp_q.pop_front();
                check("prdata", bus.prdata_o, r.rdata);
                check("pslverr", bus.pslverr_o, r.err);
                check("pready_access_cycle", acc_cyc, r.lat);
            end
        end
        if (bus.app_en_o && bus.app_rdy_i) begin
            if (bus.app_cmd_o == APP_CMD_READ) rd_hs_cnt++;
            if (cmd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_cmd: got addr %0h cmd %0h, expected none", bus.app_addr_o, bus.app_cmd_o);
            end else begin
                cmd_t c;
                c = cmd_q.pop_front();
                check("app_addr", bus.app_addr_o, c.addr);
                check("app_cmd", bus.app_cmd_o, c.cmd);
            end
        end
        if (bus.app_wdf_wren_o && bus.app_wdf_rdy_i) begin
            if (wdf_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_wdf: got mask %0h, expected none", bus.app_wdf_mask_o);
            end else begin
                wdf_t w;
                w = wdf_q.pop_front();
                check("wdf_data", bus.app_wdf_data_o, w.data);
                check("wdf_mask", bus.app_wdf_mask_o, w.mask);
                check("wdf_end", bus.app_wdf_end_o, 1'b1);
            end
        end
        if (bus.app_en_o && !en_prev) en_rises++;
        if (bus.app_en_o) en_run++;
        else if (en_prev) begin last_en_len = en_run; en_run = 0; end
        en_prev = bus.app_en_o;
    end

    // MIG model: ready after a configurable number of request cycles (-1 = never),
    // read line returned rd_dly cycles after the read command is accepted.
    initial begin
        int en_cyc = 0, wdf_cyc = 0, rd_cd = 0, rd_seen = 0;
        bus.app_rdy_i = 1'b0;
        bus.app_wdf_rdy_i = 1'b0;
        bus.app_rd_data_valid_i = 1'b0;
        forever begin
            @(posedge pclk); #1;
            if (bus.app_en_o) en_cyc++; else en_cyc = 0;
            bus.app_rdy_i = (cmd_dly >= 0) && (en_cyc > cmd_dly);
            if (bus.app_wdf_wren_o) wdf_cyc++; else wdf_cyc = 0;
            bus.app_wdf_rdy_i = (wdf_dly >= 0) && (wdf_cyc > wdf_dly);
            if (rd_hs_cnt != rd_seen) begin rd_seen = rd_hs_cnt; rd_cd = rd_dly; end
            if (rd_cd > 0) begin
                rd_cd--;
                bus.app_rd_data_valid_i = (rd_cd == 0);
            end else begin
                bus.app_rd_data_valid_i = 1'b0;
            end
        end
    end

    // APB requester: setup, access, hold until pready. Call at posedge+1.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic [31:0] exp_rdata,
                            input logic exp_err, input int exp_lat);
        int n;
        resp_q.push_back('{exp_rdata, exp_err, exp_lat});
        bus.psel_i = 1'b1; bus.penable_i = 1'b0; bus.pwrite_i = wr;
        bus.paddr_i = addr; bus.pwdata_i = wdata; bus.pstrb_i = strb;
        @(posedge pclk); #1;
        bus.penable_i = 1'b1;
        n = 0;
        do begin @(negedge pclk); n++; end while (!bus.pready_o && n < 100);
        if (!bus.pready_o) begin
            checks++; errors++;
            $display("FAIL apb_wait: got no pready after %0d cycles, expected pready", n);
        end
        @(posedge pclk); #1;
        bus.psel_i = 1'b0; bus.penable_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge pclk); #1; end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion, expected finish before 300000");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.paddr_i = '0; bus.pwdata_i = '0; bus.pwrite_i = 1'b0;
        bus.psel_i = 1'b0; bus.penable_i = 1'b0; bus.pstrb_i = '0;
        bus.init_calib_complete_i = 1'b1;
        repeat (3) @(negedge pclk);
        check("reset_outputs_zero", outs_zero(), 1'b1);
        check("reset_state", dut.state, ST_IDLE);
        @(posedge pclk); #1;
        preset = 1'b0;
        idle(2);

        // Full-word write, lane 1, everything ready: pready in access cycle 3.
        expect_cmd(27'h10, APP_CMD_WRITE);
        expect_wdf({4{32'hDEADBEEF}}, 16'hFF0F);
        apb_xfer(1'b1, 32'h24, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 3);
        idle(1);

        // Read lane 2, line returned 5 cycles after the command.
        rd_line = {32'hA3A3A3A3, 32'h12345678, 32'hA1A1A1A1, 32'hA0A0A0A0};
        expect_cmd(27'h10, APP_CMD_READ);
        apb_xfer(1'b0, 32'h28, 32'h0, 4'h0, 32'h12345678, 1'b0, 8);
        check("read_en_len", last_en_len, 1);
        idle(1);

        // Command accepted 3 cycles before write data.
        cmd_dly = 0; wdf_dly = 3;
        expect_cmd(27'h0, APP_CMD_WRITE);
        expect_wdf({4{32'h01020304}}, 16'hFFF0);
        apb_xfer(1'b1, 32'h0, 32'h01020304, 4'hF, 32'h0, 1'b0, 6);
        check("cmd_first_en_len", last_en_len, 1);
        idle(1);

        // Write data accepted 3 cycles before the command.
        cmd_dly = 3; wdf_dly = 0;
        expect_cmd(27'h80, APP_CMD_WRITE);
        expect_wdf({4{32'hCAFEF00D}}, 16'hFCFF);
        apb_xfer(1'b1, 32'h108, 32'hCAFEF00D, 4'b0011, 32'h0, 1'b0, 6);
        check("wdf_first_en_len", last_en_len, 4);
        cmd_dly = 0; wdf_dly = 0;
        idle(1);

        // Sparse strobes in lane 3.
        expect_cmd(27'h18, APP_CMD_WRITE);
        expect_wdf({4{32'h55AA55AA}}, 16'hAFFF);
        apb_xfer(1'b1, 32'h3C, 32'h55AA55AA, 4'b0101, 32'h0, 1'b0, 3);
        idle(1);

        // Highest legal address, lane 0.
        expect_cmd(27'h7FFFFF8, APP_CMD_READ);
        apb_xfer(1'b0, 32'h0FFF_FFF0, 32'h0, 4'h0, 32'hA0A0A0A0, 1'b0, 8);
        idle(1);

        // Rejected transfers: no MIG traffic, pready in access cycle 2.
        bus.init_calib_complete_i = 1'b0;
        apb_xfer(1'b0, 32'h28, 32'h0, 4'h0, 32'h0, 1'b1, 2);
        bus.init_calib_complete_i = 1'b1;
        idle(1);
        apb_xfer(1'b1, 32'h2, 32'h11111111, 4'hF, 32'h0, 1'b1, 2);
        idle(1);
        apb_xfer(1'b0, 32'h1000_0000, 32'h0, 4'h0, 32'h0, 1'b1, 2);
        idle(1);
        apb_xfer(1'b1, 32'h24, 32'h22222222, 4'h0, 32'h0, 1'b0, 2);
        idle(1);

        // Command never accepted: app_en held 8 cycles then error.
        cmd_dly = -1;
        exp_en_rises++;
        apb_xfer(1'b0, 32'h44, 32'h0, 4'h0, 32'h0, 1'b1, 10);
        check("timeout_en_len", last_en_len, TMO);
        cmd_dly = 0;
        idle(1);

        // Reset while waiting for read data; the late line must be ignored.
        rd_dly = 20;
        expect_cmd(27'h10, APP_CMD_READ);
        bus.psel_i = 1'b1; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0; bus.paddr_i = 32'h28;
        @(posedge pclk); #1;
        bus.penable_i = 1'b1;
        idle(4);
        check("pre_reset_state", dut.state, ST_RD_WAIT);
        preset = 1'b1; bus.psel_i = 1'b0; bus.penable_i = 1'b0;
        #2;
        check("midreset_outputs_zero", outs_zero(), 1'b1);
        check("midreset_state", dut.state, ST_IDLE);
        @(posedge pclk); #1;
        preset = 1'b0;
        idle(25);
        check("stale_outputs_zero", outs_zero(), 1'b1);
        check("stale_state", dut.state, ST_IDLE);

        // Normal read after the reset.
        rd_dly = 5;
        rd_line = {32'hB3B3B3B3, 32'hB2B2B2B2, 32'h600DCAFE, 32'hB0B0B0B0};
        expect_cmd(27'h10, APP_CMD_READ);
        apb_xfer(1'b0, 32'h24, 32'h0, 4'h0, 32'h600DCAFE, 1'b0, 8);
        idle(5);

        check("resp_q_drained", resp_q.size(), 0);
        check("cmd_q_drained", cmd_q.size(), 0);
        check("wdf_q_drained", wdf_q.size(), 0);
        check("app_en_pulses", en_rises, exp_en_rises);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
